// File: rtl/clock_lock_supervisor.sv
// Shared DCM lock sequencer: pulses DCM resets, retries on timeout, releases system reset after a stable lock window.
// Optional build macro CLKSUP_FAULT_RETRY_EN: FAULT retries after a 16 x LOCK_TIMEOUT hold-off instead of being terminal.
module clock_lock_supervisor #(
  parameter int NUM_DCM       = 3,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int RESET_PULSE   = 10,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4
) (
  input  logic               input_clk,
  input  logic               reset_n,
  input  logic [NUM_DCM-1:0] dcm_locked,
  output logic [NUM_DCM-1:0] dcm_reset,
  output logic               system_reset_n,
  output logic               all_locked,
  output logic [3:0]         retry_count,
  output logic               fault,
  output logic [2:0]         state
);
  localparam int BASE_MAX0 = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int BASE_MAX  = (BASE_MAX0 > RESET_PULSE) ? BASE_MAX0 : RESET_PULSE;
`ifdef CLKSUP_FAULT_RETRY_EN
  localparam int HOLDOFF   = 16 * LOCK_TIMEOUT;
  localparam int CNT_MAX   = (HOLDOFF > BASE_MAX) ? HOLDOFF : BASE_MAX;
`else
  localparam int CNT_MAX   = BASE_MAX;
`endif
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PULSE_END   = CNT_W'(RESET_PULSE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_END  = CNT_W'(STABLE_CYCLES - 1);
`ifdef CLKSUP_FAULT_RETRY_EN
  localparam logic [CNT_W-1:0] HOLD_END    = CNT_W'(HOLDOFF - 1);
`endif
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PULSE  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  logic [NUM_DCM-1:0] r_lk_meta;
  logic [NUM_DCM-1:0] r_lk;
  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [NUM_DCM-1:0] r_dcm_reset;
  logic [NUM_DCM-1:0] w_dcm_reset_nxt;
  logic               r_sys_rst_n;
  logic               w_sys_rst_n_nxt;
  logic               r_all_locked;
  logic [3:0]         r_retry;
  logic [3:0]         w_retry_nxt;
  logic [3:0]         w_retry_inc;
  logic               r_fault;
  logic               w_fault_nxt;
  logic               w_all_lk;
  logic               w_state_chg;

  // Raw LOCKED pins are asynchronous to input_clk.
  always_ff @(posedge input_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lk_meta <= '0;
      r_lk      <= '0;
    end else begin
      r_lk_meta <= dcm_locked;
      r_lk      <= r_lk_meta;
    end
  end

  assign w_all_lk    = &r_lk;
  assign w_retry_inc = r_retry + 4'd1;
  assign w_state_chg = (w_next_state != r_state);

  always_ff @(posedge input_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_PULSE;
      r_cnt        <= '0;
      r_dcm_reset  <= '1;
      r_sys_rst_n  <= 1'b0;
      r_all_locked <= 1'b0;
      r_retry      <= 4'd0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_cnt_nxt;
      r_dcm_reset  <= w_dcm_reset_nxt;
      r_sys_rst_n  <= w_sys_rst_n_nxt;
      r_all_locked <= w_all_lk;
      r_retry      <= w_retry_nxt;
      r_fault      <= w_fault_nxt;
    end
  end

  // Lock beats timeout when both happen in the same WAIT_LOCK cycle.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_PULSE:  if (r_cnt == PULSE_END) w_next_state = S_WAIT;
      S_WAIT: begin
        if (w_all_lk)                  w_next_state = S_STABLE;
        else if (r_cnt == TIMEOUT_END) w_next_state = (w_retry_inc == RETRY_LIMIT) ? S_FAULT : S_PULSE;
      end
      S_STABLE: begin
        if (!w_all_lk)                w_next_state = S_WAIT;
        else if (r_cnt == STABLE_END) w_next_state = S_RUN;
      end
      S_RUN:    if (!w_all_lk) w_next_state = S_PULSE;
      S_FAULT: begin
`ifdef CLKSUP_FAULT_RETRY_EN
        if (r_cnt == HOLD_END) w_next_state = S_PULSE;
`endif
      end
      default:  w_next_state = S_PULSE;
    endcase
  end

  // Retry mask is latched into dcm_reset on PULSE entry and held for the whole pulse.
  always_comb begin
    w_cnt_nxt       = w_state_chg ? '0 : r_cnt + 1'b1;
    w_dcm_reset_nxt = '0;
    if (w_next_state == S_PULSE) begin
      if (!w_state_chg)           w_dcm_reset_nxt = r_dcm_reset;
      else if (r_state == S_FAULT) w_dcm_reset_nxt = '1;
      else                         w_dcm_reset_nxt = ~r_lk;
    end
    w_sys_rst_n_nxt = (r_state == S_RUN) && (w_next_state == S_RUN);
    w_fault_nxt     = (w_next_state == S_FAULT);
    w_retry_nxt     = r_retry;
    if (r_state == S_WAIT && w_state_chg && w_next_state != S_STABLE)
      w_retry_nxt = w_retry_inc;
    else if (r_state == S_STABLE && w_next_state == S_RUN)
      w_retry_nxt = 4'd0;
    else if (r_state == S_FAULT && w_next_state == S_PULSE)
      w_retry_nxt = 4'd0;
  end

  assign dcm_reset      = r_dcm_reset;
  assign system_reset_n = r_sys_rst_n;
  assign all_locked     = r_all_locked;
  assign retry_count    = r_retry;
  assign fault          = r_fault;
  assign state          = r_state;

endmodule

// File: tb/tb_clock_lock_supervisor.sv
// Directed scenarios plus randomized lock patterns for clock_lock_supervisor, checked against a phase-level reference model.
module tb_clock_lock_supervisor;
  localparam int LT = 100;
  localparam int RP = 10;
  localparam int SC = 16;
  localparam int MR = 3;

  localparam int P_PULSE  = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_FAULT  = 4;

  logic       clk;
  logic       reset_n;
  logic [2:0] dcm_locked;
  logic [2:0] dcm_reset;
  logic       system_reset_n;
  logic       all_locked;
  logic [3:0] retry_count;
  logic       fault;
  logic [2:0] state;

  int vectors;
  int miscompares;

  // Reference model: phase, cycles spent in phase, retries, and the raw->lk pipeline.
  int         m_phase;
  int         m_time;
  int         m_retry;
  logic [2:0] m_lk;
  logic [2:0] m_meta;
  logic [2:0] e_dcm;
  logic       e_srst;
  logic       e_all;
  logic       e_fault;

  clock_lock_supervisor #(
    .NUM_DCM(3), .LOCK_TIMEOUT(LT), .RESET_PULSE(RP), .STABLE_CYCLES(SC), .MAX_RETRIES(MR)
  ) dut (
    .input_clk(clk),
    .reset_n(reset_n),
    .dcm_locked(dcm_locked),
    .dcm_reset(dcm_reset),
    .system_reset_n(system_reset_n),
    .all_locked(all_locked),
    .retry_count(retry_count),
    .fault(fault),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_PULSE;
    m_time  = 0;
    m_retry = 0;
    m_lk    = 3'b000;
    m_meta  = 3'b000;
    e_dcm   = 3'b111;
    e_srst  = 1'b0;
    e_all   = 1'b0;
    e_fault = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] raw);
    bit         locked_all;
    int         nxt;
    logic [2:0] mask;
    locked_all = (m_lk == 3'b111);
    nxt  = m_phase;
    mask = 3'b111;
    case (m_phase)
      P_PULSE:  if (m_time + 1 >= RP) nxt = P_WAIT;
      P_WAIT: begin
        if (locked_all) nxt = P_STABLE;
        else if (m_time + 1 >= LT) begin
          m_retry = m_retry + 1;
          nxt  = (m_retry >= MR) ? P_FAULT : P_PULSE;
          mask = ~m_lk;
        end
      end
      P_STABLE: begin
        if (!locked_all) nxt = P_WAIT;
        else if (m_time + 1 >= SC) begin
          nxt = P_RUN;
          m_retry = 0;
        end
      end
      P_RUN: begin
        if (!locked_all) begin
          nxt  = P_PULSE;
          mask = ~m_lk;
        end
      end
      default: begin
`ifdef CLKSUP_FAULT_RETRY_EN
        if (m_time + 1 >= 16 * LT) begin
          nxt = P_PULSE;
          m_retry = 0;
          mask = 3'b111;
        end
`endif
      end
    endcase
    if (nxt != P_PULSE) e_dcm = 3'b000;
    else if (nxt != m_phase) e_dcm = mask;
    e_srst  = (m_phase == P_RUN) && (nxt == P_RUN);
    e_fault = (nxt == P_FAULT);
    e_all   = locked_all;
    m_time  = (nxt == m_phase) ? m_time + 1 : 0;
    m_phase = nxt;
    m_lk    = m_meta;
    m_meta  = raw;
  endtask

  task automatic compare_all();
    chk("state",          16'(state),          16'(m_phase));
    chk("dcm_reset",      16'(dcm_reset),      16'(e_dcm));
    chk("system_reset_n", 16'(system_reset_n), 16'(e_srst));
    chk("all_locked",     16'(all_locked),     16'(e_all));
    chk("retry_count",    16'(retry_count),    16'(m_retry));
    chk("fault",          16'(fault),          16'(e_fault));
  endtask

  task automatic cycle(input logic [2:0] raw);
    dcm_locked = raw;
    @(posedge clk);
    model_step(raw);
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_dcm_reset", 16'(dcm_reset), 16'h7);
    chk("rst_state",     16'(state),     16'h0);
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    compare_all();
  endtask

  initial begin
    int  hi;
    int  n;
    bit  done;
    logic [2:0] pat;
    vectors     = 0;
    miscompares = 0;
    dcm_locked  = 3'b000;
    reset_n     = 1'b1;
    model_reset();
    #2;
    reset_n = 1'b0;
    #1;
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    compare_all();

    // Power-up: locks arrive at cycle 30, pulse lasts RP cycles, system reset released after the window.
    hi = (dcm_reset == 3'b111) ? 1 : 0;
    for (int c = 0; c < 60; c++) begin
      cycle((c >= 30) ? 3'b111 : 3'b000);
      if (dcm_reset == 3'b111) hi++;
    end
    chk("pwrup_pulse_len", 16'(hi), 16'(RP));
    chk("pwrup_run",       16'(state), 16'(P_RUN));
    chk("pwrup_srst",      16'(system_reset_n), 16'h1);
    chk("pwrup_retry",     16'(retry_count), 16'h0);

    // One-cycle loss of DCM 2 while running.
    cycle(3'b011);
    cycle(3'b111);
    cycle(3'b111);
    chk("loss_srst_low", 16'(system_reset_n), 16'h0);
    hi = (dcm_reset == 3'b100) ? 1 : 0;
    for (int c = 0; c < 40; c++) begin
      cycle(3'b111);
      if (dcm_reset == 3'b100) hi++;
    end
    chk("loss_pulse_len", 16'(hi), 16'(RP));
    chk("loss_recover",   16'(state), 16'(P_RUN));

    // DCM 1 stays unlocked: two pulses of mask 010 and one timeout.
    hi = 0;
    for (int c = 0; c < 130; c++) begin
      cycle(3'b101);
      if (dcm_reset == 3'b010) hi++;
    end
    chk("partial_mask_cycles", 16'(hi), 16'(2 * RP));
    chk("partial_retry",       16'(retry_count), 16'h1);

    // Recover, then flicker DCM 0 at stable count 8.
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      cycle(3'b111);
      if (m_phase == P_STABLE && m_time == 6) done = 1'b1;
    end
    chk("flick_reached_stable", 16'(done), 16'h1);
    cycle(3'b110);
    cycle(3'b111);
    cycle(3'b111);
    chk("flick_wait",  16'(state), 16'(P_WAIT));
    chk("flick_retry", 16'(retry_count), 16'h1);
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      cycle(3'b111);
      if (state == 3'd2) n++;
      if (state == 3'd3) done = 1'b1;
    end
    chk("flick_window", 16'(n), 16'(SC));
    chk("flick_run_retry", 16'(retry_count), 16'h0);

    // All locks lost: MR timeouts lead to FAULT.
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      cycle(3'b000);
      if (m_phase == P_FAULT) done = 1'b1;
    end
    chk("fault_state", 16'(state), 16'(P_FAULT));
    chk("fault_retry", 16'(retry_count), 16'(MR));
    hi = (fault && dcm_reset == 3'b000 && !system_reset_n) ? 1 : 0;
`ifdef CLKSUP_FAULT_RETRY_EN
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      cycle(3'b000);
      if (fault && dcm_reset == 3'b000 && !system_reset_n) hi++;
      else done = 1'b1;
    end
    chk("fault_holdoff", 16'(hi), 16'(16 * LT));
    chk("fault_exit_state", 16'(state), 16'(P_PULSE));
    chk("fault_exit_mask",  16'(dcm_reset), 16'h7);
`else
    for (int c = 0; c < 9999; c++) begin
      cycle(3'b000);
      if (fault && dcm_reset == 3'b000 && !system_reset_n) hi++;
    end
    chk("fault_held", 16'(hi), 16'd10000);
`endif

    // Reset from FAULT, then again in the middle of WAIT_LOCK.
    async_reset();
    for (int c = 0; c < 20; c++) cycle(3'b000);
    chk("mid_wait", 16'(state), 16'(P_WAIT));
    async_reset();
    chk("mid_retry", 16'(retry_count), 16'h0);

    // Randomized lock behaviour: long stable stretches with occasional faults and glitches.
    pat = 3'b111;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 39) == 0)
        pat = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b111;
      if ($urandom_range(0, 99) == 0) cycle(pat & 3'($urandom));
      else cycle(pat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
